// File: rtl/truth_scan_pkg.sv
// Shared types and sizes for the truth-table scanner: FSM state encoding,
// vector count, index width and settle-counter width.
package truth_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } scan_state_t;

  localparam int NUM_VECTORS = 8;
  localparam int IDX_W       = 3;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/scan_settle_timer.sv
// Settle counter: counts 0..SETTLE_CYCLES-1 while run_i is high and pulses
// expire_o on the last count; load_i or expiry returns the count to zero.
module scan_settle_timer
  import truth_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic run_i,
  output logic expire_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    expire_o = run_i && (cnt_q == LAST_CNT);
    cnt_d    = cnt_q;
    if (load_i || expire_o) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/truth_table_scanner.sv
// Walks {a,b,c} through all 8 vectors, samples s after SETTLE_CYCLES per vector and
// compares the captured table with EXPECTED. SCAN_FIRST_FAIL_EN adds first-mismatch capture.
module truth_table_scanner
  import truth_scan_pkg::*;
#(
  parameter int                     SETTLE_CYCLES = 2,
  parameter logic [NUM_VECTORS-1:0] EXPECTED      = 8'h70
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic                   s_i,
  output logic                   a_o,
  output logic                   b_o,
  output logic                   c_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [NUM_VECTORS-1:0] table_o,
  output logic                   match_o
`ifdef SCAN_FIRST_FAIL_EN
  ,
  output logic                   fail_valid_o,
  output logic [IDX_W-1:0]       fail_idx_o
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

  scan_state_t            state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       abc_q, abc_d;
  logic [NUM_VECTORS-1:0] table_q, table_d;
  logic                   match_q, match_d;
  logic                   accept;
  logic                   expire;

  assign accept = (state_q == IDLE) && start_i;

  scan_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (accept),
    .run_i    (state_q == DRIVE),
    .expire_o (expire)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    table_d = table_q;
    match_d = match_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = DRIVE;
          idx_d   = '0;
          table_d = '0;
          match_d = 1'b0;
        end
      end
      DRIVE: begin
        if (expire) state_d = SAMPLE;
      end
      SAMPLE: begin
        table_d[idx_q] = s_i;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          // table_q does not hold the final sample yet, so splice s_i in directly.
          match_d = ({s_i, table_q[NUM_VECTORS-2:0]} == EXPECTED);
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = DRIVE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    abc_d = ((state_d == DRIVE) || (state_d == SAMPLE)) ? idx_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      abc_q   <= '0;
      table_q <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      abc_q   <= abc_d;
      table_q <= table_d;
      match_q <= match_d;
    end
  end

  assign {a_o, b_o, c_o} = abc_q;
  assign busy_o          = (state_q == DRIVE) || (state_q == SAMPLE);
  assign done_o          = (state_q == DONE);
  assign table_o         = table_q;
  assign match_o         = match_q;

`ifdef SCAN_FIRST_FAIL_EN
  logic             fail_valid_q, fail_valid_d;
  logic [IDX_W-1:0] fail_idx_q, fail_idx_d;

  always_comb begin
    fail_valid_d = fail_valid_q;
    fail_idx_d   = fail_idx_q;
    if (accept) begin
      fail_valid_d = 1'b0;
      fail_idx_d   = '0;
    end else if ((state_q == SAMPLE) && !fail_valid_q && (s_i != EXPECTED[idx_q])) begin
      fail_valid_d = 1'b1;
      fail_idx_d   = idx_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_valid_q <= 1'b0;
      fail_idx_q   <= '0;
    end else begin
      fail_valid_q <= fail_valid_d;
      fail_idx_q   <= fail_idx_d;
    end
  end

  assign fail_valid_o = fail_valid_q;
  assign fail_idx_o   = fail_idx_q;
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: three instances (default, EXPECTED=8'h71, SETTLE_CYCLES=1)
// each scanning a table-driven function; results checked against an arithmetic timing model.
module tb_truth_table_scanner;

  localparam int N = 3;
  localparam logic [N*4-1:0] SET_PK = {4'd1, 4'd2, 4'd2};
  localparam logic [N*8-1:0] EXP_PK = {8'h70, 8'h71, 8'h70};

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N-1:0]        start_w;
  logic [N-1:0][7:0]   func;
  logic [N-1:0]        s_w;
  logic [N-1:0]        a_w, b_w, c_w, busy_w, done_w, match_w;
  logic [N-1:0][7:0]   table_w;
`ifdef SCAN_FIRST_FAIL_EN
  logic [N-1:0]        fv_w;
  logic [N-1:0][2:0]   fi_w;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    assign s_w[g] = func[g][{a_w[g], b_w[g], c_w[g]}];

    truth_table_scanner #(
      .SETTLE_CYCLES (int'(SET_PK[g*4 +: 4])),
      .EXPECTED      (EXP_PK[g*8 +: 8])
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start_i  (start_w[g]),
      .s_i      (s_w[g]),
      .a_o      (a_w[g]),
      .b_o      (b_w[g]),
      .c_o      (c_w[g]),
      .busy_o   (busy_w[g]),
      .done_o   (done_w[g]),
      .table_o  (table_w[g]),
      .match_o  (match_w[g])
`ifdef SCAN_FIRST_FAIL_EN
      ,
      .fail_valid_o (fv_w[g]),
      .fail_idx_o   (fi_w[g])
`endif
    );
  end

  // One full scan on instance n with function table f; optional extra start pulse
  // landing on edge restart_edge (always while busy or in DONE, so it must be ignored).
  task automatic scan_check(input int n, input logic [7:0] f, input int restart_edge, input string tag);
    int         st, last, bad_abc, bad_busy, done_cnt, done_at;
    logic [7:0] ex;
    logic       eb;
    logic [2:0] ev;
    logic [2:0] efi;
    st       = int'(SET_PK[n*4 +: 4]);
    ex       = EXP_PK[n*8 +: 8];
    last     = 8 * (st + 1);
    bad_abc  = 0;
    bad_busy = 0;
    done_cnt = 0;
    done_at  = -1;
    func[n]  = f;
    @(negedge clk);
    start_w[n] = 1'b1;
    for (int k = 0; k <= last + 1; k++) begin
      @(posedge clk);
      #1;
      start_w[n] = (k + 1 == restart_edge);
      eb = (k < last);
      ev = eb ? 3'(k / (st + 1)) : 3'd0;
      if ({a_w[n], b_w[n], c_w[n]} !== ev) bad_abc++;
      if (busy_w[n] !== eb) bad_busy++;
      if (done_w[n] === 1'b1) begin
        done_cnt++;
        done_at = k;
      end
      if (k == 0) begin
        n_cmp++;
        if ({table_w[n], match_w[n]} !== 9'h000) begin
          n_fail++;
          $display("FAIL %s clear_on_start dut%0d got table=%h match=%b want 00/0", tag, n, table_w[n], match_w[n]);
        end
`ifdef SCAN_FIRST_FAIL_EN
        n_cmp++;
        if (fv_w[n] !== 1'b0) begin
          n_fail++;
          $display("FAIL %s fail_clear dut%0d got fail_valid=%b want 0", tag, n, fv_w[n]);
        end
`endif
      end
      if (k == last) begin
        n_cmp++;
        if (table_w[n] !== f || match_w[n] !== (f == ex)) begin
          n_fail++;
          $display("FAIL %s at_done dut%0d got table=%h match=%b want %h/%b", tag, n, table_w[n], match_w[n], f, (f == ex));
        end
      end
    end
    n_cmp++;
    if (bad_abc !== 0) begin
      n_fail++;
      $display("FAIL %s abc_sequence dut%0d got %0d bad cycles want 0", tag, n, bad_abc);
    end
    n_cmp++;
    if (bad_busy !== 0) begin
      n_fail++;
      $display("FAIL %s busy dut%0d got %0d bad cycles want 0", tag, n, bad_busy);
    end
    n_cmp++;
    if (done_cnt !== 1 || done_at !== last) begin
      n_fail++;
      $display("FAIL %s done_pulse dut%0d got count=%0d edge=%0d want 1/%0d", tag, n, done_cnt, done_at, last);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (table_w[n] !== f || match_w[n] !== (f == ex) || busy_w[n] !== 1'b0) begin
      n_fail++;
      $display("FAIL %s hold dut%0d got table=%h match=%b busy=%b want %h/%b/0", tag, n, table_w[n], match_w[n], busy_w[n], f, (f == ex));
    end
`ifdef SCAN_FIRST_FAIL_EN
    efi = 3'd0;
    for (int i = 7; i >= 0; i--) if (f[i] != ex[i]) efi = 3'(i);
    n_cmp++;
    if (fv_w[n] !== (f != ex) || ((f != ex) && fi_w[n] !== efi)) begin
      n_fail++;
      $display("FAIL %s first_fail dut%0d got valid=%b idx=%0d want %b/%0d", tag, n, fv_w[n], fi_w[n], (f != ex), efi);
    end
`else
    efi = 3'd0;
`endif
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    start_w = '0;
    func    = '0;
    #3;
    for (int n = 0; n < N; n++) begin
      n_cmp++;
      if ({a_w[n], b_w[n], c_w[n], busy_w[n], done_w[n], table_w[n], match_w[n]} !== 14'h0) begin
        n_fail++;
        $display("FAIL reset_values dut%0d got abc=%b%b%b busy=%b done=%b table=%h match=%b want all 0",
                 n, a_w[n], b_w[n], c_w[n], busy_w[n], done_w[n], table_w[n], match_w[n]);
      end
`ifdef SCAN_FIRST_FAIL_EN
      n_cmp++;
      if ({fv_w[n], fi_w[n]} !== 4'h0) begin
        n_fail++;
        $display("FAIL reset_fail dut%0d got valid=%b idx=%0d want 0/0", n, fv_w[n], fi_w[n]);
      end
`endif
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_default_scan();
    scan_check(0, 8'h70, -1, "default");
  endtask

  task automatic test_expected_mismatch();
    scan_check(1, 8'h70, -1, "exp71");
  endtask

  task automatic test_stuck_one();
    scan_check(2, 8'hFF, -1, "stuck1");
  endtask

  task automatic test_restart_busy();
    scan_check(0, 8'h70, 13, "restart_busy");
    scan_check(0, 8'h70, 25, "restart_done");
  endtask

  task automatic test_abort_reset();
    int bad;
    bad     = 0;
    func[0] = 8'($urandom) | 8'h07;
    @(negedge clk);
    start_w[0] = 1'b1;
    @(posedge clk);
    #1;
    start_w[0] = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({a_w[0], b_w[0], c_w[0], busy_w[0], done_w[0], table_w[0], match_w[0]} !== 14'h0) begin
      n_fail++;
      $display("FAIL abort_reset got abc=%b%b%b busy=%b done=%b table=%h match=%b want all 0",
               a_w[0], b_w[0], c_w[0], busy_w[0], done_w[0], table_w[0], match_w[0]);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (done_w[0] !== 1'b0 || busy_w[0] !== 1'b0 || table_w[0] !== 8'h00) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL abort_no_done got %0d bad cycles want 0", bad);
    end
    scan_check(0, 8'h70, -1, "after_abort");
  endtask

  task automatic test_back_to_back();
    int   st, last, scan_start, next_acc, bad, bad_tbl, scans, dones, d;
    logic eb, ed;
    logic [2:0] ev;
    st         = int'(SET_PK[3:0]);
    last       = 8 * (st + 1);
    scan_start = -1000;
    next_acc   = 0;
    bad        = 0;
    bad_tbl    = 0;
    scans      = 0;
    dones      = 0;
    func[0]    = 8'h70;
    @(negedge clk);
    start_w[0] = 1'b1;
    for (int k = 0; k < 82; k++) begin
      @(posedge clk);
      #1;
      // start is high on edges 0..59; a scan is accepted once the previous one has had its IDLE cycle
      if (k < 60 && k >= next_acc) begin
        scan_start = k;
        next_acc   = k + last + 2;
        scans++;
      end
      if (k == 59) start_w[0] = 1'b0;
      d  = k - scan_start;
      eb = (d >= 0) && (d < last);
      ed = (d == last);
      ev = eb ? 3'(d / (st + 1)) : 3'd0;
      if (busy_w[0] !== eb || done_w[0] !== ed || {a_w[0], b_w[0], c_w[0]} !== ev) bad++;
      if (done_w[0] === 1'b1) begin
        dones++;
        if (table_w[0] !== 8'h70 || match_w[0] !== 1'b1) bad_tbl++;
      end
    end
    n_cmp++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL b2b_timing got %0d bad cycles want 0", bad);
    end
    n_cmp++;
    if (dones !== scans) begin
      n_fail++;
      $display("FAIL b2b_done_count got %0d want %0d", dones, scans);
    end
    n_cmp++;
    if (bad_tbl !== 0) begin
      n_fail++;
      $display("FAIL b2b_results got %0d bad scans want 0", bad_tbl);
    end
  endtask

  task automatic test_random();
    int         n, st, re;
    logic [7:0] f;
    for (int r = 0; r < 8; r++) begin
      n  = int'($urandom_range(0, N - 1));
      st = int'(SET_PK[n*4 +: 4]);
      f  = ($urandom_range(0, 3) == 0) ? EXP_PK[n*8 +: 8] : 8'($urandom);
      re = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(1, 8 * (st + 1) + 1));
      scan_check(n, f, re, "random");
    end
  endtask

  initial begin
    test_reset();
    test_default_scan();
    test_expected_mismatch();
    test_stuck_one();
    test_restart_busy();
    test_abort_reset();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
